// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter with load, +4 advance and a pending branch target that is
// applied when the current fetch completes.
module pc_reg
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_we,
    input  logic [31:0] pc_next,
    input  logic        idle,
    input  logic        done,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    logic [31:0] pend;
    logic        pend_v;

    assign pc_plus4 = pc + 32'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= RESET_PC;
            pend   <= '0;
            pend_v <= 1'b0;
        end else if (done) begin
            // A write arriving in the completion cycle is the newest target.
            if (pc_we)       pc <= word_align(pc_next);
            else if (pend_v) pc <= pend;
            else             pc <= pc_plus4;
            pend_v <= 1'b0;
        end else if (pc_we && idle) begin
            pc <= word_align(pc_next);
        end else if (pc_we) begin
            pend   <= word_align(pc_next);
            pend_v <= 1'b1;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, runs the imem read handshake, strobes the IR.
// Optional read timeout in WAIT is enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = DEFAULT_RESET_PC,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_start,
    input  logic        pc_we,
    input  logic [31:0] pc_next,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        ir_in,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        busy,
    output logic        fetch_err
);

    fetch_state_e state;
    logic         st_idle;
    logic         st_done;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    assign st_idle   = (state == IDLE);
    assign st_done   = (state == DONE);
    assign imem_req  = (state == REQ);
    assign imem_addr = word_align(pc);
    assign ir_in     = st_done;
    assign busy      = !st_idle;

    pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .pc_we    (pc_we),
        .pc_next  (pc_next),
        .idle     (st_idle),
        .done     (st_done),
        .pc       (pc),
        .pc_plus4 (pc_plus4)
    );

`ifdef FETCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CW-1:0] wait_cnt;
    logic          err_q;
    logic          expired;

    // Counts completed WAIT cycles; expiry is the last allowed WAIT cycle.
    assign expired   = (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign fetch_err = err_q;
`else
    assign fetch_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            instr <= NOP;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
`ifdef FETCH_TIMEOUT_EN
            err_q <= 1'b0;
`endif
            case (state)
                IDLE: if (fetch_start) state <= REQ;
                REQ: begin
                    if (imem_gnt) begin
                        if (imem_rvalid) begin
                            instr <= imem_rdata;
                            state <= DONE;
                        end else begin
                            state <= WAIT;
                        end
`ifdef FETCH_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                    end
                end
                WAIT: begin
                    // rvalid beats expiry when both land in the same cycle.
                    if (imem_rvalid) begin
                        instr <= imem_rdata;
                        state <= DONE;
                    end
`ifdef FETCH_TIMEOUT_EN
                    else if (expired) begin
                        instr <= NOP;
                        err_q <= 1'b1;
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed fetches plus randomized
// handshake latencies against a transaction-level PC/IR model.
module tb_instr_fetch_unit;
    import fetch_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam int          TO     = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_start = 1'b0;
    logic        pc_we = 1'b0;
    logic [31:0] pc_next = '0;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] instr;
    logic        ir_in;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        busy;
    logic        fetch_err;

    instr_fetch_unit #(.RESET_PC(RST_PC), .TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_start (fetch_start),
        .pc_we       (pc_we),
        .pc_next     (pc_next),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .ir_in       (ir_in),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .busy        (busy),
        .fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Reference state: architectural PC, IR contents and pending branch target.
    logic [31:0] m_pc = RST_PC;
    logic [31:0] m_instr = '0;
    logic [31:0] m_pend = '0;
    bit          m_pend_v = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One fetch transaction. rv_dly < 0 means rvalid never comes (timeout).
    // we_at >= 0 forces pc_we with we_tgt on that busy cycle index.
    task automatic fetch(input int gnt_dly, input int rv_dly, input logic [31:0] rdata,
                         input bit ld_idle, input logic [31:0] ld_tgt,
                         input int we_at, input logic [31:0] we_tgt,
                         input int we_pct, input bit spam);
        int          reqs = 0;
        int          irs = 0;
        int          errs = 0;
        int          busy_cyc = 0;
        bit          ended = 1'b0;
        logic [31:0] addr = '0;
        logic [31:0] cap = '0;
        logic [31:0] exp_addr;
        chk("instr_hold", instr, m_instr);
        fetch_start = 1'b1;
        if (ld_idle) begin
            pc_we   = 1'b1;
            pc_next = ld_tgt;
            m_pc    = ld_tgt & 32'hFFFF_FFFC;
        end
        exp_addr = m_pc;
        step();
        fetch_start = spam;
        pc_we = 1'b0;
        for (int c = 0; c < 64; c++) begin
            if (fetch_err) errs++;
            if (!busy) begin
                ended = 1'b1;
                break;
            end
            busy_cyc++;
            if (imem_req) begin
                reqs++;
                addr = imem_addr;
            end
            if (ir_in) begin
                irs++;
                cap = instr;
            end
            imem_gnt    = (c == gnt_dly);
            imem_rvalid = (rv_dly >= 0) && (c == gnt_dly + rv_dly);
            imem_rdata  = imem_rvalid ? rdata : $urandom;
            pc_we       = ($urandom_range(99) < we_pct);
            pc_next     = $urandom;
            if (c == we_at) begin
                pc_we   = 1'b1;
                pc_next = we_tgt;
            end
            if (pc_we) begin
                m_pend_v = 1'b1;
                m_pend   = pc_next & 32'hFFFF_FFFC;
            end
            fetch_start = spam;
            step();
        end
        fetch_start = 1'b0;
        pc_we       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        chk("fetch_ended", 32'(ended), 32'd1);
        chk("req_cycles", reqs, gnt_dly + 1);
        chk("req_addr", addr, exp_addr);
        if (rv_dly < 0) begin
            chk("err_pulses", errs, 1);
            chk("ir_in_count", irs, 0);
            chk("busy_cycles", busy_cyc, gnt_dly + 1 + TO);
            m_instr = NOP;
        end else begin
            chk("err_pulses", errs, 0);
            chk("ir_in_count", irs, 1);
            chk("ir_data", cap, rdata);
            chk("busy_cycles", busy_cyc, gnt_dly + rv_dly + 2);
            m_instr  = rdata;
            m_pc     = m_pend_v ? m_pend : m_pc + 32'd4;
            m_pend_v = 1'b0;
        end
        chk("instr", instr, m_instr);
        chk("pc", pc, m_pc);
        chk("pc_plus4", pc_plus4, m_pc + 32'd4);
        step();
        chk("no_refetch", {29'd0, busy, imem_req, ir_in}, 32'd0);
    endtask

    initial begin
        #12;
        chk("rst_pc", pc, RST_PC);
        chk("rst_instr", instr, 32'h0);
        chk("rst_ctl", {28'd0, busy, imem_req, ir_in, fetch_err}, 32'd0);
        rst_n = 1'b1;
        step();

        // Fastest path, then delayed grant and delayed data.
        fetch(0, 0, 32'h2008_0005, 0, '0, -1, '0, 0, 0);
        fetch(3, 2, $urandom, 0, '0, -1, '0, 0, 0);

        // Branch target written during WAIT replaces +4; next fetch uses it.
        fetch(0, 3, $urandom, 0, '0, 2, 32'h0000_3042, 0, 0);
        chk("branch_pc", pc, 32'h0000_3040);
        fetch(1, 1, $urandom, 0, '0, -1, '0, 0, 0);

        // PC wrap, with fetch_start held through the whole fetch.
        pc_we = 1'b1;
        pc_next = 32'hFFFF_FFFF;
        step();
        pc_we = 1'b0;
        m_pc = 32'hFFFF_FFFC;
        chk("load_idle_pc", pc, m_pc);
        fetch(1, 1, $urandom, 0, '0, -1, '0, 0, 1);
        chk("wrap_pc", pc, 32'h0);

        // Load and start in the same cycle: fetch uses the new PC.
        fetch(0, 1, $urandom, 1, 32'h0000_8123, -1, '0, 0, 0);

        // Reset in WAIT, late rvalid afterwards is ignored.
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        m_pc = RST_PC;
        m_instr = NOP;
        m_pend_v = 1'b0;
        step();
        imem_rvalid = 1'b1;
        imem_rdata = $urandom;
        step();
        imem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("late_rvalid_ctl", {29'd0, busy, imem_req, ir_in}, 32'd0);
            step();
        end
        chk("rst_mid_pc", pc, RST_PC);
        chk("rst_mid_instr", instr, 32'h0);

`ifdef FETCH_TIMEOUT_EN
        fetch(0, -1, $urandom, 0, '0, -1, '0, 0, 0);
        fetch(2, TO, $urandom, 0, '0, -1, '0, 0, 0);
        fetch(1, -1, $urandom, 0, '0, 4, 32'h0000_5000, 0, 1);
        fetch(0, 0, $urandom, 0, '0, -1, '0, 0, 0);
`endif

        for (int i = 0; i < 25; i++) begin
            fetch($urandom_range(4), $urandom_range(5), $urandom,
                  $urandom_range(3) == 0, $urandom, -1, '0,
                  ($urandom_range(1) == 1) ? 20 : 0, $urandom_range(1) == 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Producer side of the instruction-register interface in the multicycle CPU.
- Owns the PC and runs an instruction-memory read handshake with variable latency.
- Delivers the fetched word on `instr` with a one-cycle `ir_in` strobe to the IR.
- Advances the PC by 4, or to a control-supplied target, after each fetch.

Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset.
- TIMEOUT_CYCLES, 16, maximum cycles waiting for rvalid after grant; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fetch_start  in  1  control unit requests one fetch; sampled only in IDLE.
- pc_we  in  1  load pc_next as the next PC.
- pc_next  in  32  branch/jump target.
- imem_req  out  1  read request to instruction memory.
- imem_addr  out  32  word-aligned read address.
- imem_gnt  in  1  memory accepted the request.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  32  read data.
- instr  out  32  registered fetched instruction, to IR.
- ir_in  out  1  one-cycle strobe, instr valid, to IR.
- pc  out  32  current PC.
- pc_plus4  out  32  pc + 4, combinational, for the link register.
- busy  out  1  high in any state other than IDLE.
- fetch_err  out  1  one-cycle timeout pulse; only with FETCH_TIMEOUT_EN, otherwise tied 0.

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE; pc = RESET_PC; instr = 0.
  - ir_in, imem_req, busy, fetch_err all 0; pending-target flag cleared.
  - Reset mid-fetch abandons the transaction; any late rvalid arriving in IDLE is ignored.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE: on fetch_start go to REQ. imem_req is driven combinationally from state.
  - REQ: imem_req = 1, imem_addr = {pc[31:2], 2'b00}. Hold until imem_gnt.
    - gnt without rvalid: go to WAIT.
    - gnt with rvalid in the same cycle: capture data, go to DONE.
  - WAIT: imem_req = 0. On imem_rvalid: instr <= imem_rdata, go to DONE.
  - DONE: ir_in = 1 for exactly this cycle.
    - pc <= pending target if set, else pc + 4; clear pending.
    - Return to IDLE. fetch_start in DONE is ignored.
- Minimum latency: fetch_start at edge t, gnt+rvalid at t+1, ir_in high during cycle t+2.
- instr holds its last value between fetches; it changes only on capture.
- PC update rules:
  - pc_we in IDLE: pc <= {pc_next[31:2], 2'b00} next edge.
  - pc_we and fetch_start together in IDLE: the load takes effect first, and the fetch uses the new PC.
  - pc_we while busy: target latched into a pending register and applied in DONE instead of pc+4. A later pc_we overwrites an earlier pending one.
- Arithmetic: pc + 4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- fetch_start while busy is ignored. No queueing.

Optional Feature:
- FETCH_TIMEOUT_EN defined:
  - A counter starts on entry to WAIT.
  - If rvalid has not arrived after TIMEOUT_CYCLES cycles in WAIT: fetch_err pulses 1 cycle, instr <= 32'h0000_0000 (NOP), no ir_in, pc unchanged, pending kept, state returns to IDLE.
  - rvalid arriving in the same cycle the count expires wins: normal completion.
- FETCH_TIMEOUT_EN undefined: WAIT is unbounded, fetch_err is constant 0, no counter logic.

Decomposition:
- Package fetch_pkg holds:
  - the state enum (IDLE/REQ/WAIT/DONE);
  - the NOP constant;
  - the default RESET_PC.
- One sub-module, pc_reg: PC register with async reset, load, increment-by-4, and the pending-target register.

Test Plan:
- Reset release, fetch_start, gnt+rvalid in the same cycle, rdata 32'h2008_0005 -> imem_addr 32'h0000_3000; ir_in for one cycle two cycles after start; instr = 32'h2008_0005; pc = 32'h0000_3004.
- gnt delayed 3 cycles, rvalid 2 cycles after gnt -> imem_req held 4 cycles then drops; single ir_in pulse; busy high throughout.
- pc_we with pc_next 32'h0000_3042 while in WAIT -> after DONE, pc = 32'h0000_3040 (not +4); next fetch addresses 32'h0000_3040.
- pc = 32'hFFFF_FFFC, fetch -> pc wraps to 32'h0000_0000; fetch_start asserted during the fetch produces no second request.
- rst_n low during WAIT, then late rvalid after release -> state IDLE, pc = RESET_PC, no ir_in, instr = 0.
- With FETCH_TIMEOUT_EN: gnt with no rvalid for 16 cycles -> fetch_err pulse, instr = 0, pc unchanged, no ir_in. Second run: rvalid on the expiry cycle -> normal completion, no fetch_err.
